// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

  // Smallest frame payload; data_bits selects DATA_BITS_BASE + 0..3 bits.
  localparam int unsigned DATA_BITS_BASE = 5;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Mask keeping only the data bits a frame actually carries.
  function automatic logic [7:0] data_mask(input logic [1:0] data_bits);
    return 8'hFF >> (2'd3 - data_bits);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small first-word-fall-through byte FIFO feeding the transmitter.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == (AW + 1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr];
  assign cnt    = r_cnt;

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + (AW + 1)'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with a small transmit FIFO.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          TX,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          overflow
);

  tx_state_t        r_state;
  logic [DIV_W-1:0] r_baud_cnt;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_idx;
  logic [2:0]       r_last_bit;
  logic             r_par_en;
  logic             r_par_bit;
  logic             r_two_stop;
  logic             r_stop_idx;
  logic             r_tx;
  logic             r_done;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_fifo_dout;
  logic             w_tick;
  logic             w_stop_end;
  logic             w_pop;
  logic             w_push;
  logic [7:0]       w_load_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (wr_data),
    .dout  (w_fifo_dout),
    .cnt   (fifo_cnt),
    .full  (w_full),
    .empty (w_empty)
  );

  // Bit boundary and frame-end decode; a pop at frame end chains the next frame.
  always_comb begin
    w_tick      = (r_baud_cnt == r_div);
    w_stop_end  = (r_state == STOP) && w_tick && (!r_two_stop || r_stop_idx);
    w_pop       = !w_empty && ((r_state == IDLE) || w_stop_end);
    // Full is judged on the registered count, so a same-cycle pop does not help.
    w_push      = wr_en && !w_full;
    w_load_data = w_fifo_dout & data_mask(data_bits);
  end

  // Frame FSM, baud counter and registered serial output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_div      <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_last_bit <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= 1'b0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= w_stop_end;
      if (wr_en && w_full) r_overflow <= 1'b1;

      if (w_pop) begin
        // Latch the whole frame configuration; later input changes are ignored.
        r_state    <= START;
        r_baud_cnt <= '0;
        r_div      <= baud_div;
        r_shift    <= w_load_data;
        r_bit_idx  <= '0;
        r_last_bit <= 3'(DATA_BITS_BASE - 1) + 3'(data_bits);
        r_par_en   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
        r_par_bit  <= (^w_load_data) ^ (parity_mode == PAR_ODD);
        r_two_stop <= two_stop;
        r_stop_idx <= 1'b0;
        r_tx       <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
          end
          START: begin
            if (w_tick) begin
              r_baud_cnt <= '0;
              r_state    <= DATA;
              r_tx       <= r_shift[0];
            end else begin
              r_baud_cnt <= r_baud_cnt + DIV_W'(1);
            end
          end
          DATA: begin
            if (w_tick) begin
              r_baud_cnt <= '0;
              if (r_bit_idx == r_last_bit) begin
                if (r_par_en) begin
                  r_state <= PARITY;
                  r_tx    <= r_par_bit;
                end else begin
                  r_state    <= STOP;
                  r_tx       <= 1'b1;
                  r_stop_idx <= 1'b0;
                end
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
                r_shift   <= r_shift >> 1;
                r_tx      <= r_shift[1];
              end
            end else begin
              r_baud_cnt <= r_baud_cnt + DIV_W'(1);
            end
          end
          PARITY: begin
            if (w_tick) begin
              r_baud_cnt <= '0;
              r_state    <= STOP;
              r_tx       <= 1'b1;
              r_stop_idx <= 1'b0;
            end else begin
              r_baud_cnt <= r_baud_cnt + DIV_W'(1);
            end
          end
          STOP: begin
            if (w_tick) begin
              r_baud_cnt <= '0;
              if (r_two_stop && !r_stop_idx) begin
                r_stop_idx <= 1'b1;
              end else begin
                r_state <= IDLE;
                r_tx    <= 1'b1;
              end
            end else begin
              r_baud_cnt <= r_baud_cnt + DIV_W'(1);
            end
          end
          default: begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign full     = w_full;
  assign TX       = r_tx;
  assign busy     = (r_state != IDLE);
  assign tx_done  = r_done;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: vector table plus multi-frame sequences.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic [2:0]  fifo_cnt;
  logic        TX;
  logic        busy;
  logic        tx_done;
  logic        overflow;

  uart_tx_cfg #(
    .DIV_W      (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_div    (baud_div),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .fifo_cnt    (fifo_cnt),
    .TX          (TX),
    .busy        (busy),
    .tx_done     (tx_done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] bits;
    int          n;
    int          per;
  } frame_t;

  typedef struct {
    logic [1:0]  db;
    logic [1:0]  pm;
    logic        ts;
    logic [15:0] div;
    logic [7:0]  data;
    int          exp_len;
  } vec_t;

  frame_t exp_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     frames_seen = 0;
  bit     mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: start, LSB-first data, optional parity, stop bit(s).
  function automatic frame_t model(input logic [1:0] db, input logic [1:0] pm, input logic ts,
                                   input logic [15:0] div, input logic [7:0] d);
    frame_t f;
    int     k;
    int     nd;
    logic   p;
    nd = int'(db) + 5;
    f.bits = '0;
    p = 1'b0;
    f.bits[0] = 1'b0;
    k = 1;
    for (int i = 0; i < nd; i++) begin
      f.bits[k] = d[i];
      p = p ^ d[i];
      k++;
    end
    if (pm == 2'd1) begin
      f.bits[k] = p;
      k++;
    end else if (pm == 2'd2) begin
      f.bits[k] = ~p;
      k++;
    end
    f.bits[k] = 1'b1;
    k++;
    if (ts) begin
      f.bits[k] = 1'b1;
      k++;
    end
    f.n = k;
    f.per = int'(div) + 1;
    return f;
  endfunction

  // Line monitor: pops the expected frame when a start bit appears and checks every cycle.
  initial begin : monitor
    frame_t      e;
    int          len;
    int          mism;
    int          early;
    int          guard;
    logic [11:0] cap;
    bit          pending;
    pending = 1'b0;
    forever begin
      if (!pending) @(negedge clk);
      pending = 1'b0;
      if (mon_en && TX === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(exp_q.size()), 32'd1);
          guard = 0;
          while (TX === 1'b0 && guard < 1000) begin
            @(negedge clk);
            guard++;
          end
        end else begin
          e = exp_q.pop_front();
          len = e.n * e.per;
          cap = '0;
          mism = 0;
          early = 0;
          for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            if (TX !== e.bits[c / e.per]) mism++;
            if ((c % e.per) == (e.per / 2)) cap[c / e.per] = TX;
            if (c > 0 && tx_done) early++;
          end
          @(negedge clk);
          check("frame_bits", 32'(cap), 32'(e.bits));
          check("bit_stable", 32'(mism), 32'd0);
          check("done_early", 32'(early), 32'd0);
          check("done_pulse", 32'(tx_done), 32'd1);
          frames_seen++;
          pending = 1'b1;
        end
      end
    end
  end

  task automatic set_cfg(input logic [1:0] db, input logic [1:0] pm, input logic ts,
                         input logic [15:0] div);
    data_bits = db;
    parity_mode = pm;
    two_stop = ts;
    baud_div = div;
  endtask

  // Call at a negedge; one write is sampled on the following posedge.
  task automatic push_byte(input logic [7:0] d, input bit expect_frame);
    wr_en = 1'b1;
    wr_data = d;
    if (expect_frame) exp_q.push_back(model(data_bits, parity_mode, two_stop, baud_div, d));
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    int guard;
    guard = 0;
    while (!tx_done && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    seen = tx_done;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  vec_t vecs[7];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          t0;
    int          nd;
    int          drops;
    int          guard;
    int          f0;
    int          lows;
    int          dones;
    int          dt[3];
    bit          seen;

    vecs[0] = '{2'd3, 2'd0, 1'b0, 16'd3, 8'hA5, 40};  // 8N1
    vecs[1] = '{2'd2, 2'd1, 1'b1, 16'd1, 8'h53, 22};  // 7E2
    vecs[2] = '{2'd0, 2'd2, 1'b0, 16'd0, 8'hFF, 8};   // 5O1, upper bits ignored
    vecs[3] = '{2'd1, 2'd0, 1'b1, 16'd2, 8'h2C, 27};  // 6N2
    vecs[4] = '{2'd3, 2'd2, 1'b0, 16'd0, 8'h00, 11};  // 8O1, parity bit 1
    vecs[5] = '{2'd0, 2'd1, 1'b1, 16'd1, 8'h16, 18};  // 5E2
    vecs[6] = '{2'd2, 2'd3, 1'b0, 16'd1, 8'h7F, 18};  // mode 3 sends no parity

    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    set_cfg(2'd3, 2'd0, 1'b0, 16'd3);
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_cnt", 32'(fifo_cnt), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      set_cfg(vecs[i].db, vecs[i].pm, vecs[i].ts, vecs[i].div);
      push_byte(vecs[i].data, 1'b1);
      check("lat_tx_idle", 32'(TX), 32'd1);
      check("lat_cnt", 32'(fifo_cnt), 32'd1);
      @(negedge clk);
      check("lat_tx_low", 32'(TX), 32'd0);
      check("busy_on", 32'(busy), 32'd1);
      t0 = int'(cyc);
      wait_done(400, seen);
      check("frame_len", 32'(int'(cyc) - t0), 32'(vecs[i].exp_len));
      check("busy_off", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // Back-to-back frames: no idle gap, busy never drops.
    set_cfg(2'd3, 2'd0, 1'b0, 16'd1);
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    nd = 0;
    drops = 0;
    guard = 0;
    while (nd < 3 && guard < 200) begin
      if (tx_done) begin
        dt[nd] = int'(cyc);
        nd++;
        if (nd < 3 && !busy) drops++;
      end else if (!busy) begin
        drops++;
      end
      if (nd < 3) @(negedge clk);
      guard++;
    end
    check("b2b_frames", 32'(nd), 32'd3);
    check("b2b_gap1", 32'(dt[1] - dt[0]), 32'd20);
    check("b2b_gap2", 32'(dt[2] - dt[1]), 32'd20);
    check("b2b_busy", 32'(drops), 32'd0);
    repeat (3) @(negedge clk);

    // Config change right after load must not affect the frame in flight.
    set_cfg(2'd3, 2'd0, 1'b0, 16'd1);
    push_byte(8'hC3, 1'b1);
    @(negedge clk);
    set_cfg(2'd0, 2'd1, 1'b1, 16'd0);
    wait_done(100, seen);
    check("cfg_hold_len_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    // Fill FIFO behind a long frame, then push exactly on the frame-end pop edge.
    f0 = frames_seen;
    set_cfg(2'd3, 2'd0, 1'b0, 16'd9);
    push_byte(8'hA0, 1'b1);
    @(negedge clk);
    t0 = int'(cyc);
    push_byte(8'hB1, 1'b1);
    push_byte(8'hB2, 1'b1);
    push_byte(8'hB3, 1'b1);
    check("fill_full_3", 32'(full), 32'd0);
    push_byte(8'hB4, 1'b1);
    check("fill_full", 32'(full), 32'd1);
    check("fill_cnt", 32'(fifo_cnt), 32'd4);
    check("fill_ovf", 32'(overflow), 32'd0);
    while (int'(cyc) < t0 + 99) @(negedge clk);
    push_byte(8'hF5, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_cnt", 32'(fifo_cnt), 32'd3);
    check("ovf_done", 32'(tx_done), 32'd1);
    guard = 0;
    while (frames_seen < f0 + 5 && guard < 700) begin
      @(negedge clk);
      guard++;
    end
    repeat (30) @(negedge clk);
    check("ovf_frames", 32'(frames_seen - f0), 32'd5);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_queue", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 3: frame aborts, nothing completes.
    mon_en = 1'b0;
    set_cfg(2'd3, 2'd0, 1'b0, 16'd3);
    push_byte(8'h5A, 1'b0);
    @(negedge clk);
    t0 = int'(cyc);
    push_byte(8'h77, 1'b0);
    while (int'(cyc) < t0 + 17) @(negedge clk);
    check("mid_bit3", 32'(TX), 32'd1);
    check("mid_cnt", 32'(fifo_cnt), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", 32'(TX), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cnt", 32'(fifo_cnt), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    check("abort_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    lows = 0;
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (TX !== 1'b1) lows++;
      if (tx_done) dones++;
    end
    check("abort_quiet_tx", 32'(lows), 32'd0);
    check("abort_no_done", 32'(dones), 32'd0);
    mon_en = 1'b1;

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
